// File: rtl/sfp_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sfp_link_ctrl
// Description : SFP/PCS link bring-up sequencer with retry limit, fault latch
//               and link-drop counting.
// Revision    : 1.0 - initial release
// ============================================================================
module sfp_link_ctrl #(
    parameter logic [15:0] DISABLE_CYCLES = 16'd1000,
    parameter logic [15:0] RST_CYCLES     = 16'd256,
    parameter logic [23:0] LOCK_TIMEOUT   = 24'd1000000,
    parameter logic [3:0]  RETRY_MAX      = 4'd8
) (
    input  logic       clk100,
    input  logic       sys_rst_n,
    input  logic       enable,
    input  logic       tx_fault,
    input  logic       rx_los,
    input  logic       clk_alarm_b,
    input  logic       block_lock,
    output logic       tx_disable,
    output logic       pcs_reset,
    output logic       link_up,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic [7:0] link_drops
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TX_OFF    = 3'd1,
        PCS_RST   = 3'd2,
        WAIT_LOCK = 3'd3,
        LINK_UP   = 3'd4,
        FAULT     = 3'd5
    } state_t;

    // A programmed dwell of zero still spends one cycle in the state.
    localparam logic [23:0] c_disable_load = (DISABLE_CYCLES == 16'd0) ? 24'd1 : {8'd0, DISABLE_CYCLES};
    localparam logic [23:0] c_rst_load     = (RST_CYCLES == 16'd0)     ? 24'd1 : {8'd0, RST_CYCLES};
    localparam logic [23:0] c_lock_load    = (LOCK_TIMEOUT == 24'd0)   ? 24'd1 : LOCK_TIMEOUT;

    logic [1:0]  r_rst_sync;
    logic [1:0]  r_tx_fault_sync;
    logic [1:0]  r_rx_los_sync;
    logic [1:0]  r_clk_alarm_b_sync;
    logic [1:0]  r_block_lock_sync;
    state_t      r_state;
    state_t      w_next;
    logic [23:0] r_timer;
    logic [23:0] w_timer_load;
    logic        w_expired;
    logic        w_retry_inc;
    logic [3:0]  r_retry_cnt;
    logic [7:0]  r_link_drops;
    logic        r_tx_disable, r_pcs_reset, r_link_up, r_fault;
    logic        w_tx_disable, w_pcs_reset;

    wire w_tx_fault_s    = r_tx_fault_sync[1];
    wire w_rx_los_s      = r_rx_los_sync[1];
    wire w_clk_alarm_b_s = r_clk_alarm_b_sync[1];
    wire w_block_lock_s  = r_block_lock_sync[1];

    always_ff @(posedge clk100 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rst_sync         <= 2'b00;
            r_tx_fault_sync    <= 2'b00;
            r_rx_los_sync      <= 2'b00;
            r_clk_alarm_b_sync <= 2'b00;
            r_block_lock_sync  <= 2'b00;
        end else begin
            r_rst_sync         <= {r_rst_sync[0], 1'b1};
            r_tx_fault_sync    <= {r_tx_fault_sync[0], tx_fault};
            r_rx_los_sync      <= {r_rx_los_sync[0], rx_los};
            r_clk_alarm_b_sync <= {r_clk_alarm_b_sync[0], clk_alarm_b};
            r_block_lock_sync  <= {r_block_lock_sync[0], block_lock};
        end
    end

    assign w_expired = (r_timer <= 24'd1);

    always_comb begin
        w_next       = r_state;
        w_retry_inc  = 1'b0;
        w_timer_load = 24'd0;
        if (!r_rst_sync[1] || !enable) begin
            w_next = IDLE;
        end else if (w_tx_fault_s && (r_state == TX_OFF || r_state == PCS_RST ||
                                      r_state == WAIT_LOCK || r_state == LINK_UP)) begin
            w_next = FAULT;
        end else begin
            case (r_state)
                IDLE:      w_next = TX_OFF;
                TX_OFF:    if (w_expired && w_clk_alarm_b_s) w_next = PCS_RST;
                PCS_RST: begin
                    if (!w_clk_alarm_b_s)  w_next = TX_OFF;
                    else if (w_expired)    w_next = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    // Lock beats a coincident timeout; a clock alarm aborts without charging a retry.
                    if (w_block_lock_s && !w_rx_los_s) begin
                        w_next = LINK_UP;
                    end else if (!w_clk_alarm_b_s) begin
                        w_next = TX_OFF;
                    end else if (w_expired) begin
                        w_retry_inc = 1'b1;
                        w_next      = (r_retry_cnt + 4'd1 == RETRY_MAX) ? FAULT : TX_OFF;
                    end
                end
                LINK_UP:   if (w_rx_los_s || !w_block_lock_s || !w_clk_alarm_b_s) w_next = TX_OFF;
                FAULT:     w_next = FAULT;
                default:   w_next = IDLE;
            endcase
        end

        case (w_next)
            TX_OFF:    w_timer_load = c_disable_load;
            PCS_RST:   w_timer_load = c_rst_load;
            WAIT_LOCK: w_timer_load = c_lock_load;
            default:   w_timer_load = 24'd0;
        endcase

        w_tx_disable = (w_next == IDLE) || (w_next == TX_OFF) || (w_next == FAULT);
        w_pcs_reset  = w_tx_disable || (w_next == PCS_RST);
    end

    always_ff @(posedge clk100 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= IDLE;
            r_timer      <= 24'd0;
            r_retry_cnt  <= 4'd0;
            r_link_drops <= 8'd0;
            r_tx_disable <= 1'b1;
            r_pcs_reset  <= 1'b1;
            r_link_up    <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_timer <= w_timer_load;
            else if (r_timer != 24'd0)
                r_timer <= r_timer - 24'd1;

            if (w_next == IDLE || w_next == LINK_UP)
                r_retry_cnt <= 4'd0;
            else if (w_retry_inc)
                r_retry_cnt <= r_retry_cnt + 4'd1;

            // Exits forced by enable going low are deliberate, not drops.
            if (r_state == LINK_UP && w_next != LINK_UP && enable && r_link_drops != 8'hFF)
                r_link_drops <= r_link_drops + 8'd1;

            r_tx_disable <= w_tx_disable;
            r_pcs_reset  <= w_pcs_reset;
            r_link_up    <= (w_next == LINK_UP);
            r_fault      <= (w_next == FAULT);
        end
    end

    assign state      = r_state;
    assign tx_disable = r_tx_disable;
    assign pcs_reset  = r_pcs_reset;
    assign link_up    = r_link_up;
    assign fault      = r_fault;
    assign retry_cnt  = r_retry_cnt;
    assign link_drops = r_link_drops;

endmodule
`default_nettype wire

// File: tb/tb_sfp_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfp_link_ctrl
// Description : Self-checking bench for sfp_link_ctrl against a dwell-count
//               reference model of the link bring-up rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfp_link_ctrl;

    localparam int C_DIS   = 4;
    localparam int C_RST   = 4;
    localparam int C_LOCK  = 16;
    localparam int C_RETRY = 3;

    logic       clk100 = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       enable = 1'b0, tx_fault = 1'b0, rx_los = 1'b0, clk_alarm_b = 1'b1, block_lock = 1'b0;
    logic       tx_disable, pcs_reset, link_up, fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] link_drops;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: state as a plain integer, time-in-state counted upward.
    int         m_state, m_dwell, m_retry, m_drops, m_rcnt;
    logic [3:0] m_s1, m_s2;   // {tx_fault, rx_los, clk_alarm_b, block_lock} two-cycle delay line

    sfp_link_ctrl #(
        .DISABLE_CYCLES(16'd4),
        .RST_CYCLES    (16'd4),
        .LOCK_TIMEOUT  (24'd16),
        .RETRY_MAX     (4'd3)
    ) dut (
        .clk100     (clk100),
        .sys_rst_n  (sys_rst_n),
        .enable     (enable),
        .tx_fault   (tx_fault),
        .rx_los     (rx_los),
        .clk_alarm_b(clk_alarm_b),
        .block_lock (block_lock),
        .tx_disable (tx_disable),
        .pcs_reset  (pcs_reset),
        .link_up    (link_up),
        .fault      (fault),
        .state      (state),
        .retry_cnt  (retry_cnt),
        .link_drops (link_drops)
    );

    always #5 clk100 = ~clk100;

    function automatic logic [18:0] obs();
        return {state, tx_disable, pcs_reset, link_up, fault, retry_cnt, link_drops};
    endfunction

    function automatic logic [18:0] expv();
        logic txd, pcs, lu, flt;
        txd = (m_state == 0) || (m_state == 1) || (m_state == 5);
        pcs = txd || (m_state == 2);
        lu  = (m_state == 4);
        flt = (m_state == 5);
        return {3'(m_state), txd, pcs, lu, flt, 4'(m_retry), 8'(m_drops)};
    endfunction

    function automatic int dwell_limit(input int s);
        int p;
        case (s)
            1:       p = C_DIS;
            2:       p = C_RST;
            3:       p = C_LOCK;
            default: p = 1 << 30;
        endcase
        return (p < 1) ? 1 : p;
    endfunction

    task automatic mdl_reset();
        m_state = 0; m_dwell = 1; m_retry = 0; m_drops = 0; m_rcnt = 0;
        m_s1 = 4'b0; m_s2 = 4'b0;
    endtask

    // One clock edge: advance the model with the inputs the edge sampled, then settle.
    task automatic tick();
        int  nxt;
        bit  tf, los, alm, lk, expd;
        @(posedge clk100);
        if (!sys_rst_n) begin
            mdl_reset();
        end else begin
            tf = m_s2[3]; los = m_s2[2]; alm = m_s2[1]; lk = m_s2[0];
            expd = (m_dwell >= dwell_limit(m_state));
            nxt = m_state;
            if (m_rcnt < 2 || !enable) nxt = 0;
            else if (tf && m_state >= 1 && m_state <= 4) nxt = 5;
            else begin
                case (m_state)
                    0: nxt = 1;
                    1: if (expd && alm) nxt = 2;
                    2: if (!alm) nxt = 1; else if (expd) nxt = 3;
                    3: begin
                        if (lk && !los) nxt = 4;
                        else if (!alm) nxt = 1;
                        else if (expd) begin
                            m_retry = m_retry + 1;
                            nxt = (m_retry == C_RETRY) ? 5 : 1;
                        end
                    end
                    4: if (los || !lk || !alm) nxt = 1;
                    default: nxt = 5;
                endcase
            end
            if (m_state == 4 && nxt != 4 && enable && m_drops < 255) m_drops = m_drops + 1;
            if (nxt == 0 || nxt == 4) m_retry = 0;
            m_dwell = (nxt == m_state) ? m_dwell + 1 : 1;
            m_state = nxt;
            m_s2 = m_s1;
            m_s1 = {tx_fault, rx_los, clk_alarm_b, block_lock};
            if (m_rcnt < 2) m_rcnt = m_rcnt + 1;
        end
        #1;
    endtask

    task automatic do_reset(input logic en, input logic alarm, input logic lock);
        sys_rst_n = 1'b0;
        enable = en; tx_fault = 1'b0; rx_los = 1'b0; clk_alarm_b = alarm; block_lock = lock;
        mdl_reset();
        tick();
        tick();
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        enable = 1'b1; clk_alarm_b = 1'b1; block_lock = 1'b1; tx_fault = 1'b0; rx_los = 1'b0;
        mdl_reset();
        #1;
        n_cmp++;
        if (obs() !== 19'b000_1_1_0_0_0000_00000000) begin
            n_fail++; $display("FAIL reset_values: got %h expected %h", obs(), 19'b000_1_1_0_0_0000_00000000);
        end
        tick();
        n_cmp++;
        if (obs() !== expv()) begin n_fail++; $display("FAIL reset_held: got %h expected %h", obs(), expv()); end
        sys_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL reset_release cyc %0d: got %h expected %h", i, obs(), expv());
            end
            if (i == 1) begin
                n_cmp++;
                if (state !== 3'd0) begin n_fail++; $display("FAIL reset_release_hold: got state %0d expected 0", state); end
            end
        end
    endtask

    task automatic test_bring_up();
        int n_txoff = 0, n_pcs = 0;
        do_reset(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (state === 3'd1) n_txoff++;
            if (state === 3'd2) n_pcs++;
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL bring_up cyc %0d: got %h expected %h", i, obs(), expv());
            end
        end
        n_cmp++;
        if (n_txoff != C_DIS) begin n_fail++; $display("FAIL bring_up_txoff_dwell: got %0d expected %0d", n_txoff, C_DIS); end
        n_cmp++;
        if (n_pcs != C_RST) begin n_fail++; $display("FAIL bring_up_pcs_dwell: got %0d expected %0d", n_pcs, C_RST); end
        n_cmp++;
        if ({link_up, tx_disable} !== 2'b10) begin
            n_fail++; $display("FAIL bring_up_final: got link_up=%b tx_disable=%b expected 1/0", link_up, tx_disable);
        end
    endtask

    task automatic test_lock_timeout();
        logic [11:0] seq = 12'h0;
        logic [3:0]  last = 4'd0;
        do_reset(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 110; i++) begin
            tick();
            if (retry_cnt !== last) begin seq = {seq[7:0], retry_cnt}; last = retry_cnt; end
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL lock_timeout cyc %0d: got %h expected %h", i, obs(), expv());
            end
        end
        n_cmp++;
        if (seq !== 12'h123) begin n_fail++; $display("FAIL retry_sequence: got %h expected 123", seq); end
        n_cmp++;
        if ({fault, tx_disable, retry_cnt} !== 6'b11_0011) begin
            n_fail++; $display("FAIL timeout_fault: got fault=%b tx_disable=%b retry=%0d expected 1/1/3", fault, tx_disable, retry_cnt);
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if ({state, retry_cnt, fault} !== 8'b000_0000_0 || obs() !== expv()) begin
            n_fail++; $display("FAIL fault_exit: got %h expected %h", obs(), expv());
        end
    endtask

    task automatic test_link_drop();
        do_reset(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL drop_setup cyc %0d: got %h expected %h", i, obs(), expv()); end
        end
        rx_los = 1'b1;
        tick();
        rx_los = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_cmp++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL drop_recover cyc %0d: got %h expected %h", i, obs(), expv()); end
        end
        n_cmp++;
        if (link_drops !== 8'd1 || link_up !== 1'b1) begin
            n_fail++; $display("FAIL drop_count: got drops=%0d link_up=%b expected 1/1", link_drops, link_up);
        end
    endtask

    task automatic test_tx_fault();
        do_reset(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && state !== 3'd3; i++) tick();
        n_cmp++;
        if (state !== 3'd3) begin n_fail++; $display("FAIL reach_wait_lock: got state %0d expected 3", state); end
        tx_fault = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL tx_fault_entry cyc %0d: got %h expected %h", i, obs(), expv()); end
        end
        n_cmp++;
        if (fault !== 1'b1) begin n_fail++; $display("FAIL tx_fault_latency: got fault=%b expected 1", fault); end
        tx_fault = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (fault !== 1'b1 || state !== 3'd5) begin
            n_fail++; $display("FAIL fault_sticky: got fault=%b state=%0d expected 1/5", fault, state);
        end
    endtask

    task automatic test_clk_alarm();
        do_reset(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL alarm_hold cyc %0d: got %h expected %h", i, obs(), expv()); end
        end
        n_cmp++;
        if (state !== 3'd1) begin n_fail++; $display("FAIL alarm_txoff: got state %0d expected 1", state); end
        clk_alarm_b = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (state !== 3'd1) begin n_fail++; $display("FAIL alarm_sync_delay: got state %0d expected 1", state); end
        tick();
        n_cmp++;
        if (state !== 3'd2 || retry_cnt !== 4'd0) begin
            n_fail++; $display("FAIL alarm_release: got state=%0d retry=%0d expected 2/0", state, retry_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20 && state !== 3'd2; i++) tick();
        n_cmp++;
        if (state !== 3'd2) begin n_fail++; $display("FAIL reach_pcs_rst: got state %0d expected 2", state); end
        #2;
        sys_rst_n = 1'b0;
        mdl_reset();
        #1;
        n_cmp++;
        if (obs() !== 19'b000_1_1_0_0_0000_00000000) begin
            n_fail++; $display("FAIL async_reset: got %h expected %h", obs(), 19'b000_1_1_0_0_0000_00000000);
        end
        tick();
        sys_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL async_rerun cyc %0d: got %h expected %h", i, obs(), expv()); end
        end
    endtask

    task automatic test_random();
        do_reset(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            enable   = ($urandom_range(0, 199) != 0);
            tx_fault = ($urandom_range(0, 499) == 0);
            rx_los   = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 24) == 0) block_lock  = ~block_lock;
            if ($urandom_range(0, 49) == 0) clk_alarm_b = ~clk_alarm_b;
            tick();
            n_cmp++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL random cyc %0d: got %h expected %h", i, obs(), expv()); end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_bring_up();
        test_lock_timeout();
        test_link_drop();
        test_tx_fault();
        test_clk_alarm();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sfp_link_ctrl.md
SFP_LINK_CTRL -- requirements
Module: sfp_link_ctrl

Interface
REQ-001 Parameter DISABLE_CYCLES, default 16'd1000: cycles the TX laser is held disabled before each bring-up attempt.
REQ-002 Parameter RST_CYCLES, default 16'd256: cycles PCS reset is held after the laser is enabled.
REQ-003 Parameter LOCK_TIMEOUT, default 24'd1000000: cycles allowed for block lock per attempt.
REQ-004 Parameter RETRY_MAX, default 4'd8: consecutive failed attempts before entering FAULT.
REQ-005 Clock and reset: one clock, clk100; reset is sys_rst_n, asynchronous and active-low.
REQ-006 clk100  input  1  system clock, 100 MHz.
REQ-007 sys_rst_n  input  1  asynchronous active-low reset.
REQ-008 enable  input  1  synchronous request to bring the link up; low forces IDLE.
REQ-009 tx_fault  input  1  SFP TX_FAULT, asynchronous, active-high.
REQ-010 rx_los  input  1  SFP RX_LOS, asynchronous, active-high.
REQ-011 clk_alarm_b  input  1  SFP reference clock alarm, asynchronous, active-low.
REQ-012 block_lock  input  1  PCS block lock, asynchronous to clk100.
REQ-013 tx_disable  output  1  SFP TX_DISABLE drive.
REQ-014 pcs_reset  output  1  active-high reset to the PCS/PMA core.
REQ-015 link_up  output  1  high only in LINK_UP.
REQ-016 fault  output  1  high only in FAULT.
REQ-017 state  output  3  current state encoding.
REQ-018 retry_cnt  output  4  failed attempts since the last LINK_UP.
REQ-019 link_drops  output  8  saturating count of LINK_UP exits, excluding exits caused by enable going low.

Function
REQ-020 Synchronization: tx_fault, rx_los, clk_alarm_b and block_lock each pass through a 2-flop synchronizer (_s suffix); these signals reach the FSM 2 cycles after the input changes.
REQ-021 State encoding: IDLE=0, TX_OFF=1, PCS_RST=2, WAIT_LOCK=3, LINK_UP=4, FAULT=5; codes 6-7 return to IDLE on the next cycle.
REQ-022 Outputs are registered and decoded from the state register; they change in the same cycle as state.
REQ-023 Output table, (tx_disable, pcs_reset):
- IDLE (1,1)
- TX_OFF (1,1)
- PCS_RST (0,1)
- WAIT_LOCK (0,0)
- LINK_UP (0,0)
- FAULT (1,1)
REQ-024 A single down-counter timer is loaded on entry to TX_OFF, PCS_RST and WAIT_LOCK, so the FSM dwells exactly N cycles (N = DISABLE_CYCLES, RST_CYCLES or LOCK_TIMEOUT respectively); a value of 0 is treated as 1.
REQ-025 Transition priority, highest first:
- enable==0 -> IDLE, from any state.
- tx_fault_s==1 -> FAULT, from TX_OFF, PCS_RST, WAIT_LOCK or LINK_UP.
- The state-specific rules in REQ-026 to REQ-031.
REQ-026 IDLE: enable==1 -> TX_OFF.
REQ-027 TX_OFF: on timer expiry, if clk_alarm_b_s==1 -> PCS_RST; otherwise hold TX_OFF until clk_alarm_b_s==1.
REQ-028 PCS_RST: timer expiry -> WAIT_LOCK; clk_alarm_b_s==0 -> TX_OFF.
REQ-029 WAIT_LOCK:
- block_lock_s==1 and rx_los_s==0 -> LINK_UP.
- Else on timer expiry, retry_cnt increments; if the new value equals RETRY_MAX -> FAULT, otherwise -> TX_OFF.
- clk_alarm_b_s==0 -> TX_OFF without incrementing retry_cnt.
- If lock and expiry occur in the same cycle, lock wins.
REQ-030 LINK_UP:
- On entry, retry_cnt clears to 0.
- rx_los_s==1, block_lock_s==0 or clk_alarm_b_s==0 -> TX_OFF, and link_drops increments, saturating at 255.
REQ-031 FAULT: sticky; exits only through enable==0, which returns to IDLE; retry_cnt clears on entry to IDLE.
REQ-032 enable low mid-attempt: abort immediately to IDLE; timer contents are discarded.

Reset
REQ-033 While sys_rst_n==0:
- state=IDLE, tx_disable=1, pcs_reset=1, link_up=0, fault=0.
- retry_cnt=0, link_drops=0, timer=0, synchronizer flops=0.
REQ-034 Reset deassertion is synchronized internally (2-flop release); the FSM leaves IDLE no earlier than the 2nd clk100 edge after release.

Verification
Parameters for all scenarios: DISABLE_CYCLES=4, RST_CYCLES=4, LOCK_TIMEOUT=16, RETRY_MAX=3.
REQ-035 Nominal bring-up: enable=1, clk_alarm_b=1, block_lock held 1 -> TX_OFF for 4 cycles, PCS_RST for 4, then WAIT_LOCK, then link_up=1 and tx_disable=0.
REQ-036 Lock never asserts -> 3 timeouts, retry_cnt goes 1, 2, 3 -> fault=1, tx_disable=1; drop enable -> IDLE and retry_cnt=0.
REQ-037 In LINK_UP, pulse rx_los high for 1 cycle -> TX_OFF, link_drops=1, then full re-bring-up to link_up=1.
REQ-038 tx_fault asserted in WAIT_LOCK -> FAULT within 3 cycles; tx_fault then cleared -> remains in FAULT.
REQ-039 clk_alarm_b=0 during TX_OFF expiry -> holds TX_OFF; release -> PCS_RST next cycle after sync (+2), retry_cnt unchanged.
REQ-040 Assert sys_rst_n=0 mid-PCS_RST -> all outputs take reset values immediately (asynchronous), with no clock edge required.
